cpu_bus1_master: RTL and testbench

Bus‑1 master that sits directly upstream of the cache and stands in for the CPU. It accepts one request at a time on a simple valid/ready port and serialises it onto the shared tri‑state bus 1 (A1/D1/C1) using the two‑tick address protocol. It waits for the cache's C1_RESPONSE, collects read data, and returns it on a one‑cycle response strobe. A watchdog aborts transactions the cache never answers.

---
 rtl/cpu_bus1_master_pkg.sv | 51 +++++
 rtl/cpu_bus1_master_bus1_driver.sv | 42 ++++
 rtl/cpu_bus1_master.sv | 181 ++++++++++++++++++
 tb/tb_cpu_bus1_master.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus1_master_pkg.sv
// Shared bus-1 parameters, command encodings and small decode helpers.
package cpu_bus1_master_pkg;

  localparam int TAG_BITS       = 10;
  localparam int SET_BITS       = 5;
  localparam int OFFSET_BITS    = 4;
  localparam int ADDR1_BUS_SIZE = TAG_BITS + SET_BITS;
  localparam int REQ_ADDR_BITS  = ADDR1_BUS_SIZE + OFFSET_BITS;
  localparam int DATA1_BUS_SIZE = 16;
  localparam int CTR1_BUS_SIZE  = 3;
  localparam int REQ_DATA_BITS  = 2 * DATA1_BUS_SIZE;

  // Eight codes share a 3-bit bus. C1_RESPONSE reuses the WRITE32 code: the
  // two never collide because the cache only drives C1 while the master has
  // released it. A request carrying code 7 is therefore a WRITE32.
  localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 3'd0;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 3'd1;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 3'd2;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 3'd3;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 3'd5;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 3'd6;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 3'd7;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 3'd7;

  function automatic logic is_read(input logic [CTR1_BUS_SIZE-1:0] cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  // Only NOP has nothing to put on the bus; every other code is a real command.
  function automatic logic is_supported(input logic [CTR1_BUS_SIZE-1:0] cmd);
    return cmd != C1_NOP;
  endfunction

  // Low half of read data as returned to the requester: narrow reads are
  // zero-extended from the bytes they actually asked for.
  function automatic logic [DATA1_BUS_SIZE-1:0] read_low(
    input logic [CTR1_BUS_SIZE-1:0]  cmd,
    input logic [DATA1_BUS_SIZE-1:0] d1
  );
    logic [DATA1_BUS_SIZE-1:0] res;
    res = d1;
    if (cmd == C1_READ8) res = {8'h00, d1[7:0]};
    return res;
  endfunction

endpackage

// File: rtl/cpu_bus1_master_bus1_driver.sv
// Registered drive values and output enables for the A1/D1/C1 tri-state bus.
module cpu_bus1_master_bus1_driver
  import cpu_bus1_master_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR1_BUS_SIZE-1:0] a1_d,
  input  logic                      a1_oe_d,
  input  logic [DATA1_BUS_SIZE-1:0] d1_d,
  input  logic                      d1_oe_d,
  input  logic [CTR1_BUS_SIZE-1:0]  c1_d,
  input  logic                      c1_oe_d,
  output logic [ADDR1_BUS_SIZE-1:0] a1_q,
  output logic                      a1_oe_q,
  output logic [DATA1_BUS_SIZE-1:0] d1_q,
  output logic                      d1_oe_q,
  output logic [CTR1_BUS_SIZE-1:0]  c1_q,
  output logic                      c1_oe_q
);

  // Bus output registers; reset leaves only C1 driven, with NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q    <= '0;
      a1_oe_q <= 1'b0;
      d1_q    <= '0;
      d1_oe_q <= 1'b0;
      c1_q    <= C1_NOP;
      c1_oe_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // pre-edge values regardless of statement order.
      a1_q    <= a1_d;
      a1_oe_q <= a1_oe_d;
      d1_q    <= d1_d;
      d1_oe_q <= d1_oe_d;
      c1_q    <= c1_d;
      c1_oe_q <= c1_oe_d;
    end
  end

endmodule

// File: rtl/cpu_bus1_master.sv
// Bus-1 master: serialises one valid/ready request onto A1/D1/C1 using the
// two-tick address protocol, waits for C1_RESPONSE and returns the result.
module cpu_bus1_master
  import cpu_bus1_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CTR1_BUS_SIZE-1:0]  req_cmd,
  input  logic [REQ_ADDR_BITS-1:0]  req_addr,
  input  logic [REQ_DATA_BITS-1:0]  req_wdata,
  output logic                      rsp_valid,
  output logic [REQ_DATA_BITS-1:0]  rsp_rdata,
  output logic                      rsp_timeout,
  inout  wire  [ADDR1_BUS_SIZE-1:0] A1,
  inout  wire  [DATA1_BUS_SIZE-1:0] D1,
  inout  wire  [CTR1_BUS_SIZE-1:0]  C1
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR1,
    ADDR2,
    WAIT,
    RECV2,
    DONE
  } state_e;

  // Last watchdog value allowed in WAIT; the next tick would reach TIMEOUT.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [CTR1_BUS_SIZE-1:0]  cmd_q,   cmd_d;
  logic [REQ_ADDR_BITS-1:0]  addr_q,  addr_d;
  logic [REQ_DATA_BITS-1:0]  wdata_q, wdata_d;
  logic [REQ_DATA_BITS-1:0]  rdata_q, rdata_d;
  logic [7:0]                wdog_q,  wdog_d;
  logic                      timeout_q, timeout_d;

  logic [ADDR1_BUS_SIZE-1:0] a1_d, a1_q;
  logic [DATA1_BUS_SIZE-1:0] d1_d, d1_q;
  logic [CTR1_BUS_SIZE-1:0]  c1_d, c1_q;
  logic                      a1_oe_d, d1_oe_d, c1_oe_d;
  logic                      a1_oe, d1_oe, c1_oe;

  // State and transaction registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cmd_q     <= C1_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: request capture, watchdog and response data capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d     = req_cmd;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = is_supported(req_cmd) ? ADDR1 : DONE;
        end
      end
      ADDR1: state_d = ADDR2;
      ADDR2: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (C1 == C1_RESPONSE) begin
          if (is_read(cmd_q)) rdata_d[DATA1_BUS_SIZE-1:0] = read_low(cmd_q, D1);
          state_d = (cmd_q == C1_READ32) ? RECV2 : DONE;
        end else if (wdog_q >= WDOG_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
        end
      end
      RECV2: begin
        rdata_d[REQ_DATA_BITS-1:DATA1_BUS_SIZE] = D1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus drive for the upcoming state, so the registered outputs line up with it.
  always_comb begin
    a1_d    = '0;
    a1_oe_d = 1'b0;
    d1_d    = '0;
    d1_oe_d = 1'b0;
    c1_d    = C1_NOP;
    c1_oe_d = 1'b0;

    unique case (state_d)
      IDLE, DONE: c1_oe_d = 1'b1;
      ADDR1: begin
        c1_oe_d = 1'b1;
        c1_d    = cmd_d;
        a1_oe_d = 1'b1;
        a1_d    = addr_d[REQ_ADDR_BITS-1:OFFSET_BITS];
        if (is_write(cmd_d)) begin
          d1_oe_d = 1'b1;
          d1_d    = wdata_d[DATA1_BUS_SIZE-1:0];
        end
      end
      ADDR2: begin
        c1_oe_d = 1'b1;
        c1_d    = cmd_d;
        a1_oe_d = 1'b1;
        a1_d    = ADDR1_BUS_SIZE'(addr_d[OFFSET_BITS-1:0]);
        if (is_write(cmd_d)) begin
          d1_oe_d = 1'b1;
          d1_d    = (cmd_d == C1_WRITE32) ? wdata_d[REQ_DATA_BITS-1:DATA1_BUS_SIZE]
                                          : wdata_d[DATA1_BUS_SIZE-1:0];
        end
      end
      // WAIT and RECV2 belong to the cache: everything stays released.
      default: ;
    endcase
  end

  cpu_bus1_master_bus1_driver u_drv (
    .clk     (CLK),
    .rst     (RESET),
    .a1_d    (a1_d),
    .a1_oe_d (a1_oe_d),
    .d1_d    (d1_d),
    .d1_oe_d (d1_oe_d),
    .c1_d    (c1_d),
    .c1_oe_d (c1_oe_d),
    .a1_q    (a1_q),
    .a1_oe_q (a1_oe),
    .d1_q    (d1_q),
    .d1_oe_q (d1_oe),
    .c1_q    (c1_q),
    .c1_oe_q (c1_oe)
  );

  assign A1 = a1_oe ? a1_q : 'z;
  assign D1 = d1_oe ? d1_q : 'z;
  assign C1 = c1_oe ? c1_q : 'z;

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_timeout = (state_q == DONE) && timeout_q;
  assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_cpu_bus1_master.sv
// Self-checking bench for cpu_bus1_master with a behavioural cache stand-in.
module tb_cpu_bus1_master;
  import cpu_bus1_master_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  wire  [14:0] A1;
  wire  [15:0] D1;
  wire  [2:0]  C1;

  logic        cache_c1_oe;
  logic [2:0]  cache_c1;
  logic        cache_d1_oe;
  logic [15:0] cache_d1;

  int checks   = 0;
  int failures = 0;

  assign C1 = cache_c1_oe ? cache_c1 : 'z;
  assign D1 = cache_d1_oe ? cache_d1 : 'z;

  always #5 CLK = ~CLK;

  cpu_bus1_master #(.TIMEOUT(255)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .A1          (A1),
    .D1          (D1),
    .C1          (C1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cache_release();
    cache_c1_oe = 1'b0;
    cache_d1_oe = 1'b0;
  endtask

  task automatic cache_drive(input logic [15:0] data);
    cache_c1_oe = 1'b1;
    cache_c1    = C1_RESPONSE;
    cache_d1_oe = 1'b1;
    cache_d1    = data;
  endtask

  // One full transaction, started just after a negedge with the master idle.
  // The cache answers 'delay' cycles into WAIT (or never when respond=0).
  task automatic run_txn(input string name, input logic [2:0] cmd, input logic [18:0] addr,
                         input logic [31:0] wdata, input int delay, input bit respond,
                         input logic [15:0] lo, input logic [15:0] hi);
    bit          rd, wr, sup, r32, seen;
    int          exp_lat, cnt;
    logic [31:0] exp_rdata;
    logic        exp_to;
    logic [15:0] exp_d1_t2;

    // Reference expectations straight from the command semantics.
    sup = (cmd != 3'd0);
    rd  = (cmd == 3'd1) || (cmd == 3'd2) || (cmd == 3'd3);
    wr  = (cmd == 3'd5) || (cmd == 3'd6) || (cmd == 3'd7);
    r32 = (cmd == 3'd3);
    exp_to    = sup && !respond;
    exp_rdata = 32'h0;
    if (rd && respond) begin
      if (cmd == 3'd1)      exp_rdata = {24'h0, lo[7:0]};
      else if (cmd == 3'd2) exp_rdata = {16'h0, lo};
      else                  exp_rdata = {hi, lo};
    end
    exp_d1_t2 = (cmd == 3'd7) ? wdata[31:16] : wdata[15:0];
    if (!sup)          exp_lat = 1;
    else if (!respond) exp_lat = 3 + 255;
    else               exp_lat = 4 + delay + (r32 ? 1 : 0);

    check({name, ".ready_in"}, req_ready, 1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge CLK);
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < exp_lat + 4) begin
      @(negedge CLK);
      cnt++;
      cache_release();
      if (cnt == 1) req_valid = 1'b0;
      #1;
      if (sup && cnt == 1) begin
        check({name, ".a1_t1"}, A1, addr[18:4]);
        check({name, ".c1_t1"}, C1, cmd);
        check({name, ".ready_busy"}, req_ready, 0);
        if (wr) check({name, ".d1_t1"}, D1, wdata[15:0]);
        else    check({name, ".d1_off_t1"}, dut.d1_oe, 0);
      end
      if (sup && cnt == 2) begin
        check({name, ".a1_t2"}, A1, {28'h0, addr[3:0]});
        check({name, ".c1_t2"}, C1, cmd);
        if (wr) check({name, ".d1_t2"}, D1, exp_d1_t2);
        else    check({name, ".d1_off_t2"}, dut.d1_oe, 0);
      end
      if (sup && cnt == 3) begin
        check({name, ".wait_released"}, {dut.a1_oe, dut.d1_oe, dut.c1_oe}, 0);
      end
      if (rsp_valid) begin
        seen = 1;
        check({name, ".latency"}, cnt, exp_lat);
        check({name, ".rdata"}, rsp_rdata, exp_rdata);
        check({name, ".timeout"}, rsp_timeout, exp_to);
        check({name, ".done_c1_nop"}, C1, C1_NOP);
        check({name, ".done_a1d1_off"}, {dut.a1_oe, dut.d1_oe}, 0);
      end
      if (sup && respond && cnt == 3 + delay) cache_drive(lo);
      if (sup && respond && r32 && cnt == 4 + delay) cache_drive(hi);
    end
    check({name, ".rsp_seen"}, seen, 1);
    @(negedge CLK);
    cache_release();
    #1;
    check({name, ".rsp_one_cycle"}, rsp_valid, 0);
    check({name, ".ready_after"}, req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: observed=expired expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    RESET     = 1'b1;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_addr  = '0;
    req_wdata = '0;
    cache_c1  = '0;
    cache_d1  = '0;
    cache_release();

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check("rst.req_ready", req_ready, 1);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_rdata", rsp_rdata, 0);
    check("rst.rsp_timeout", rsp_timeout, 0);
    check("rst.c1_nop", C1, C1_NOP);
    check("rst.a1d1_off", {dut.a1_oe, dut.d1_oe}, 0);
    RESET = 1'b0;
    @(negedge CLK);
    #1;

    run_txn("read32", C1_READ32, 19'h12345, 32'h0, 0, 1, 16'hBEEF, 16'hDEAD);
    run_txn("write16", C1_WRITE16, 19'h00010, 32'h0000A5A5, 1, 1, 16'h1234, 16'h0);
    run_txn("inval", C1_INVALIDATE_LINE, 19'h00220, 32'h0, 2, 1, 16'h0, 16'h0);
    run_txn("no_rsp", C1_READ16, 19'h7ABCD, 32'h0, 0, 0, 16'h0, 16'h0);
    run_txn("write32", C1_WRITE32, 19'h4321F, 32'hCAFE_F00D, 3, 1, 16'h0, 16'h0);
    run_txn("nop_cmd", C1_NOP, 19'h55555, 32'h1, 0, 1, 16'h0, 16'h0);

    // Reset during WAIT of a READ8: bus returns to idle, no response follows.
    req_valid = 1'b1;
    req_cmd   = C1_READ8;
    req_addr  = 19'h0ABCD;
    req_wdata = '0;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midrst.c1_nop", C1, C1_NOP);
    check("midrst.a1d1_off", {dut.a1_oe, dut.d1_oe}, 0);
    check("midrst.rsp_valid", rsp_valid, 0);
    check("midrst.ready", req_ready, 1);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      check("midrst.no_rsp", rsp_valid, 0);
    end
    run_txn("after_rst", C1_READ8, 19'h0ABCD, 32'h0, 0, 1, 16'h77C3, 16'h0);

    // Back-to-back READ8s
    run_txn("b2b_a", C1_READ8, 19'h11111, 32'h0, 0, 1, 16'hFF81, 16'h0);
    run_txn("b2b_b", C1_READ8, 19'h22222, 32'h0, 1, 1, 16'h80FE, 16'h0);

    // Randomised traffic
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  c;
      logic [18:0] a;
      logic [31:0] w;
      logic [15:0] l, h;
      int          d;
      c = 3'($urandom_range(0, 7));
      a = 19'($urandom);
      w = $urandom;
      l = 16'($urandom);
      h = 16'($urandom);
      d = $urandom_range(0, 4);
      run_txn("rand", c, a, w, d, 1, l, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
